// File: rtl/fir_sample_pacer.sv
// Sample pacer for the 128-tap FIR stage: buffers source samples in a small FIFO
// and releases one per SAMPLE_PERIOD as a din_enable pulse, after a prefill phase.
module fir_sample_pacer #(
  parameter int DEPTH         = 8,
  parameter int SAMPLE_PERIOD = 128,
  parameter int PREFILL       = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      run,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [15:0]        in_data,
  output logic                      din_enable,
  output logic signed [15:0]        datain,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      underrun,
  output logic                      stall,
  input  logic                      clear_flags
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(SAMPLE_PERIOD);

  localparam logic [CW-1:0] CNT_LAST  = CW'(SAMPLE_PERIOD - 1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_PRIME = LW'(PREFILL);

  if (SAMPLE_PERIOD < 72) begin : g_bad_period
    $error("fir_sample_pacer: SAMPLE_PERIOD must be at least 72");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fir_sample_pacer: DEPTH must be a power of two, at least 2");
  end
  if (PREFILL < 1 || PREFILL > DEPTH) begin : g_bad_prefill
    $error("fir_sample_pacer: PREFILL must be in 1..DEPTH");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_RUN
  } state_t;

  state_t state, state_nxt;

  logic signed [15:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      cnt;
  logic               tick;
  logic               push;
  logic               pop;

  assign in_ready = (level != LVL_FULL);
  assign tick     = (state == S_RUN) && (cnt == CNT_LAST);
  assign push     = in_valid && in_ready;
  assign pop      = tick && (level != '0);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (run) state_nxt = S_PRIME;
      S_PRIME: begin
        if (!run)                    state_nxt = S_IDLE;
        else if (level >= LVL_PRIME) state_nxt = S_RUN;
      end
      S_RUN:   if (!run) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      // Counter only advances while staying in RUN; every other path restarts it at 0.
      if (state == S_RUN && state_nxt == S_RUN && !tick)
        cnt <= cnt + 1'b1;
      else
        cnt <= '0;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      din_enable <= 1'b0;
      datain     <= '0;
      underrun   <= 1'b0;
      stall      <= 1'b0;
    end else begin
      din_enable <= tick;
      // An empty-FIFO tick still pulses, holding the previous sample.
      if (pop) datain <= mem[rd_ptr];

      if (tick && level == '0) underrun <= 1'b1;
      else if (clear_flags)    underrun <= 1'b0;

      if (in_valid && !in_ready) stall <= 1'b1;
      else if (clear_flags)      stall <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_sample_pacer.sv
// Directed bench for fir_sample_pacer: pacing, prefill, hold/underrun, full/stall,
// FIFO ordering with concurrent push/pop, and asynchronous reset mid-pulse.
module tb_fir_sample_pacer;

  localparam int DEPTH   = 8;
  localparam int SP      = 128;
  localparam int PREFILL = 4;

  logic               clk         = 1'b0;
  logic               rst_n       = 1'b0;
  logic               run         = 1'b0;
  logic               in_valid    = 1'b0;
  logic               clear_flags = 1'b0;
  logic signed [15:0] in_data     = '0;
  logic               in_ready;
  logic               din_enable;
  logic signed [15:0] datain;
  logic [3:0]         level;
  logic               underrun;
  logic               stall;

  fir_sample_pacer #(
    .DEPTH        (DEPTH),
    .SAMPLE_PERIOD(SP),
    .PREFILL      (PREFILL)
  ) dut (
    .clock      (clk),
    .reset      (rst_n),
    .run        (run),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .din_enable (din_enable),
    .datain     (datain),
    .level      (level),
    .underrun   (underrun),
    .stall      (stall),
    .clear_flags(clear_flags)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int hold_err = 0;
  logic signed [15:0] ref_q[$];
  logic signed [15:0] src[32];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Counts falling edges until din_enable is seen (or max_cyc expires).
  task automatic wait_pulse(input int max_cyc, output int n);
    logic signed [15:0] prev;
    prev = datain;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!din_enable && datain !== prev) hold_err++;
    end while (!din_enable && n < max_cyc);
  endtask

  task automatic push_n(input int cnt, input logic [15:0] base);
    for (int i = 0; i < cnt; i++) begin
      in_valid = 1'b1;
      in_data  = base + 16'(i);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int n;
    int popped;
    int order_err;
    int srcidx;

    repeat (3) @(negedge clk);
    check("rst_level",    level,      0);
    check("rst_din_en",   din_enable, 0);
    check("rst_datain",   datain,     0);
    check("rst_underrun", underrun,   0);
    check("rst_stall",    stall,      0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);

    // Prime with 4 samples, then pacing at SP.
    run = 1'b1;
    push_n(4, 16'h0001);
    check("prime_level", level, 4);
    wait_pulse(200, n);
    check("first_pulse_dly", n, 129);
    check("first_din_en",    din_enable, 1);
    check("first_datain",    datain, 16'h0001);
    check("first_pop_level", level, 3);
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      check("pulse_width", din_enable, 0);
      if (k == 5) check("no_underrun_yet", underrun, 0);
      wait_pulse(200, n);
      check("pulse_spacing", n, 127);
      check("pulse_datain",  datain, (k == 5) ? 16'h0004 : 16'(k));
    end
    check("underrun_set", underrun, 1);
    check("datain_hold",  hold_err, 0);

    // Fill to full with pacing off, provoke and clear stall.
    run = 1'b0;
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
    check("underrun_clr", underrun, 0);
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h0100 + 16'(i);
      @(negedge clk);
    end
    check("full_level", level, 8);
    check("full_ready", in_ready, 0);
    @(negedge clk);
    check("stall_set", stall, 1);
    clear_flags = 1'b1;
    @(negedge clk);
    check("stall_set_wins", stall, 1);
    in_valid = 1'b0;
    @(negedge clk);
    clear_flags = 1'b0;
    check("stall_clr", stall, 0);
    check("full_level_kept", level, 8);

    // Restart from full; push exactly in the tick cycle at level 7.
    run = 1'b1;
    wait_pulse(200, n);
    check("rerun_dly",    n, 130);
    check("rerun_datain", datain, 16'h0100);
    check("rerun_level",  level, 7);
    repeat (SP - 1) @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'h0200;
    @(negedge clk);
    in_valid = 1'b0;
    check("tick_push_pulse",  din_enable, 1);
    check("tick_push_datain", datain, 16'h0101);
    check("tick_push_level",  level, 7);

    for (int i = 0; i < 6; i++) ref_q.push_back(16'h0102 + 16'(i));
    ref_q.push_back(16'h0200);
    for (int i = 0; i < 32; i++) src[i] = 16'($urandom);
    popped = 0;
    order_err = 0;
    srcidx = 0;
    for (int c = 0; c < 7000 && popped < 39; c++) begin
      @(negedge clk);
      if (din_enable) begin
        if (ref_q.size() == 0 || datain !== ref_q[0]) order_err++;
        if (ref_q.size() != 0) void'(ref_q.pop_front());
        popped++;
      end
      if (srcidx < 32 && in_ready) begin
        in_valid = 1'b1;
        in_data  = src[srcidx];
        ref_q.push_back(src[srcidx]);
        srcidx++;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("stream_pops",     popped, 39);
    check("stream_order",    order_err, 0);
    check("stream_underrun", underrun, 0);
    check("stream_stall",    stall, 0);

    // Asynchronous reset while a pulse is in flight.
    run = 1'b0;
    clear_flags = 1'b1;
    repeat (2) @(negedge clk);
    clear_flags = 1'b0;
    run = 1'b1;
    push_n(4, 16'h000A);
    wait_pulse(200, n);
    check("pre_rst_pulse",  din_enable, 1);
    check("pre_rst_datain", datain, 16'h000A);
    check("pre_rst_level",  level, 3);
    rst_n = 1'b0;
    #1;
    check("async_din_en",   din_enable, 0);
    check("async_datain",   datain, 0);
    check("async_level",    level, 0);
    check("async_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    push_n(3, 16'h0020);
    wait_pulse(300, n);
    check("prime_no_pulse",  din_enable, 0);
    check("prime_level3",    level, 3);
    push_n(1, 16'h0023);
    wait_pulse(200, n);
    check("reprime_dly",    n, 129);
    check("reprime_datain", datain, 16'h0020);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
